asrv32_mem_arbiter: RTL
=======================

# asrv32_mem_arbiter

Two-requester arbiter that shares one single-port, synchronous-read main memory between the asrv32_core instruction-fetch port and its load/store port. It sits between the core's stb/ack buses and the memory array in asrv32_soc. It serialises accesses through a small FSM with round-robin tie-breaking and returns registered read data with a one-cycle ack pulse.

## Interface
Parameters:
- MEMORY_DEPTH, 1024: memory size in bytes. AW = $clog2(MEMORY_DEPTH) is the byte-address width. The word index is addr[AW-1:2].

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_stb_inst  in  1  instruction request; level, held until o_ack_inst.
- i_inst_addr  in  AW  instruction byte address; stable while stb is high.
- o_ack_inst  out  1  one-cycle pulse; o_inst is valid in the same cycle.
- o_inst  out  32  fetched word, registered.
- i_stb_data  in  1  data request; level, held until o_ack_data.
- i_data_addr  in  AW  data byte address.
- i_data_in  in  32  store data.
- i_wr_en  in  1  1 = store, 0 = load.
- i_wr_mask  in  4  byte enables for stores.
- o_ack_data  out  1  one-cycle pulse.
- o_data_out  out  32  loaded word, registered.
- o_mem_en  out  1  memory access strobe, combinational.
- o_mem_addr  out  AW-2  word index.
- o_mem_wr_en  out  1  memory write strobe.
- o_mem_wr_mask  out  4  byte enables.
- o_mem_wdata  out  32  write data.
- i_mem_rdata  in  32  memory read data. Valid the cycle after o_mem_en. Read-first: a write returns the old word.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- Masking: in IDLE, the effective requests are stb_x gated by !ack_x. A requester whose ack is currently high is not re-granted.
- IDLE, no effective request: all o_mem_* signals low or zero; stay in IDLE.
- IDLE, one effective request: grant it.
- IDLE, both effective requests: grant the requester that was not last granted.
- On grant, drive the memory port combinationally from the winner's fields:
  - o_mem_en = 1.
  - o_mem_addr = addr[AW-1:2].
  - For the instruction port, o_mem_wr_en = 0 and o_mem_wr_mask = 0.
  - For the data port, o_mem_wr_en = i_wr_en, o_mem_wr_mask = i_wr_mask, o_mem_wdata = i_data_in.
- On grant, next state is BUSY_I or BUSY_D, and last_grant is updated.
- BUSY_I: capture i_mem_rdata into o_inst, set o_ack_inst, return to IDLE.
- BUSY_D: capture i_mem_rdata into o_data_out, set o_ack_data, return to IDLE. Stores also capture the old word.
- In BUSY_x, o_mem_* are all zero; no new grant is made.
- Ack registers self-clear after one cycle.
- No alignment checks. The low two address bits are ignored.

## Timing
- Reset values: state IDLE, o_ack_inst 0, o_ack_data 0, o_inst 0, o_data_out 0, last_grant DATA (so the instruction port wins the first tie). o_mem_* are 0 because they derive from IDLE with no requests.
- Latency: stb seen in IDLE in cycle N; memory accessed in cycle N; ack and data visible in cycle N+2.
- Throughput:
  - The same requester holding stb gets at most one access per 3 cycles: grant, busy, ack (masked).
  - With both requesters pending, grants alternate: I in N, D in N+2, I in N+4, and so on.
- The requester must drop or renew stb on the cycle after it samples ack. The arbiter treats stb high in the cycle after ack as a new request.
- Asynchronous reset mid-access:
  - The FSM returns to IDLE and acks and data registers clear immediately.
  - A write already issued in the grant cycle is not undone.
  - The pending access receives no ack; the requester must reissue after reset.

## Structure
- State encodings (IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2) and the GRANT_INST/GRANT_DATA constants go in asrv32_header.vh.
- One natural sub-module: asrv32_rr_arb2, a 2-input round-robin grant with a last_grant register and enable. The FSM and datapath muxes stay in the top.
- Replaces the combinational read path of main_memory in asrv32_soc, which then exposes a synchronous read port.

## Test plan
- Reset, then instruction request alone at i_inst_addr=0x10 with memory word 4 = 0x00500093 -> o_mem_addr=4 in cycle 0; o_ack_inst=1 and o_inst=0x00500093 in cycle 2; o_ack_data stays 0.
- Data store at addr 0x20, data 0xDEADBEEF, mask 4'b0011, memory word 8 = 0x11223344 -> o_mem_wr_en=1, mask 0011 in cycle 0; o_data_out=0x11223344 with ack in cycle 2. A subsequent load returns 0x1122BEEF.
- Both stb raised together from reset and held -> grant order I, D, I, D, with grants at cycles 0, 2, 4, 6 and each ack exactly one cycle wide.
- Instruction stb held continuously with data idle -> acks at cycles 2, 5, 8. In the ack cycles no memory access occurs (masking).
- Assert i_rst_n=0 during BUSY_D -> o_ack_data, o_data_out and the state clear asynchronously. After release, the data request reissued completes in 2 cycles.
- Load at addr 0x3FF with MEMORY_DEPTH=1024 -> o_mem_addr=255 (word wrap boundary) and the last word is returned.

Source files
------------

// File: rtl/asrv32_mem_arbiter_pkg.sv
// ============================================================================
// Module      : asrv32_mem_arbiter_pkg
// Description : Shared state encodings and grant identifiers for the
//               instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package asrv32_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/asrv32_mem_arbiter_if.sv
// ============================================================================
// Module      : asrv32_mem_arbiter_if
// Description : Core-side stb/ack buses and memory-side port of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface asrv32_mem_arbiter_if #(
    parameter int AW = 10
);
    logic          stb_inst;
    logic [AW-1:0] inst_addr;
    logic          ack_inst;
    logic [31:0]   inst;

    logic          stb_data;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_in;
    logic          wr_en;
    logic [3:0]    wr_mask;
    logic          ack_data;
    logic [31:0]   data_out;

    logic          mem_en;
    logic [AW-3:0] mem_addr;
    logic          mem_wr_en;
    logic [3:0]    mem_wr_mask;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    // Arbiter view
    modport slave (
        input  stb_inst, inst_addr, stb_data, data_addr, data_in, wr_en, wr_mask, mem_rdata,
        output ack_inst, inst, ack_data, data_out,
        output mem_en, mem_addr, mem_wr_en, mem_wr_mask, mem_wdata
    );

    // Core + memory view
    modport master (
        output stb_inst, inst_addr, stb_data, data_addr, data_in, wr_en, wr_mask, mem_rdata,
        input  ack_inst, inst, ack_data, data_out,
        input  mem_en, mem_addr, mem_wr_en, mem_wr_mask, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/asrv32_mem_arbiter_rr_arb2.sv
// ============================================================================
// Module      : asrv32_rr_arb2
// Description : Two-input round-robin grant; a tie goes to the requester
//               that was not granted last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asrv32_rr_arb2
    import asrv32_mem_arbiter_pkg::*;
(
    input  wire logic i_clk,
    input  wire logic i_rst_n,
    input  wire logic en_i,
    input  wire logic req_inst_i,
    input  wire logic req_data_i,
    output logic      gnt_inst_o,
    output logic      gnt_data_o
);
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        gnt_inst_o   = en_i & req_inst_i & (~req_data_i | (last_grant_q == GRANT_DATA));
        gnt_data_o   = en_i & req_data_i & ~gnt_inst_o;
        last_grant_d = last_grant_q;
        if (gnt_inst_o)
            last_grant_d = GRANT_INST;
        else if (gnt_data_o)
            last_grant_d = GRANT_DATA;
    end

    // Reset to DATA so the instruction port wins the first tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_grant_q <= GRANT_DATA;
        else
            last_grant_q <= last_grant_d;
    end

endmodule

`default_nettype wire

// File: rtl/asrv32_mem_arbiter.sv
// ============================================================================
// Module      : asrv32_mem_arbiter
// Description : Serialises instruction-fetch and load/store accesses onto one
//               synchronous-read memory port; registered data, one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module asrv32_mem_arbiter
    import asrv32_mem_arbiter_pkg::*;
#(
    parameter int MEMORY_DEPTH = 1024
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst_n,
    asrv32_mem_arbiter_if.slave  bus
);
    localparam int AW = $clog2(MEMORY_DEPTH);

    arb_state_e  state_q, state_d;
    logic        ack_inst_q, ack_inst_d;
    logic        ack_data_q, ack_data_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] data_q, data_d;

    logic          gnt_inst, gnt_data;
    logic          mem_en, mem_wr_en;
    logic [AW-3:0] mem_addr;
    logic [3:0]    mem_wr_mask;
    logic [31:0]   mem_wdata;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.inst_addr[1:0], bus.data_addr[1:0]};

    // A requester whose ack is high this cycle is still holding its old stb
    asrv32_rr_arb2 u_rr_arb2 (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .en_i       (state_q == ST_IDLE),
        .req_inst_i (bus.stb_inst & ~ack_inst_q),
        .req_data_i (bus.stb_data & ~ack_data_q),
        .gnt_inst_o (gnt_inst),
        .gnt_data_o (gnt_data)
    );

    always_comb begin
        state_d     = state_q;
        ack_inst_d  = 1'b0;
        ack_data_d  = 1'b0;
        inst_d      = inst_q;
        data_d      = data_q;
        mem_en      = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_mask = 4'b0000;
        mem_wdata   = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_inst) begin
                    mem_en   = 1'b1;
                    mem_addr = bus.inst_addr[AW-1:2];
                    state_d  = ST_BUSY_I;
                end else if (gnt_data) begin
                    mem_en      = 1'b1;
                    mem_addr    = bus.data_addr[AW-1:2];
                    mem_wr_en   = bus.wr_en;
                    mem_wr_mask = bus.wr_mask;
                    mem_wdata   = bus.data_in;
                    state_d     = ST_BUSY_D;
                end
            end
            ST_BUSY_I: begin
                inst_d     = bus.mem_rdata;
                ack_inst_d = 1'b1;
                state_d    = ST_IDLE;
            end
            ST_BUSY_D: begin
                data_d     = bus.mem_rdata;
                ack_data_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ack_inst_q <= 1'b0;
            ack_data_q <= 1'b0;
            inst_q     <= 32'h0;
            data_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            ack_inst_q <= ack_inst_d;
            ack_data_q <= ack_data_d;
            inst_q     <= inst_d;
            data_q     <= data_d;
        end
    end

    assign bus.ack_inst    = ack_inst_q;
    assign bus.inst        = inst_q;
    assign bus.ack_data    = ack_data_q;
    assign bus.data_out    = data_q;
    assign bus.mem_en      = mem_en;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_en   = mem_wr_en;
    assign bus.mem_wr_mask = mem_wr_mask;
    assign bus.mem_wdata   = mem_wdata;

endmodule

`default_nettype wire
